etc_lane_ctrl: RTL and testbench
================================

Name: etc_lane_ctrl

Overview:
- Parametrised next-generation controller for a nonstop ETC lane with three sensors: sensor1 at lane entry, sensor2 at the tag reader, sensor3 at the barrier exit.
- Tracks multiple vehicles in the lane at once. Queues one Epass verdict per vehicle and applies a verification timeout.
- Drives the barrier with up/down pulses and keeps it open for back-to-back paid vehicles.
- Holds a failed vehicle until the operator enables a manual release.

Parameters:
- QDEPTH, 4, verdict queue depth: max vehicles between sensor2 and sensor3 exit (power of 2, >=2)
- CNT_W, 4, occupancy counter width (vehicles between sensor1 entry and sensor3 exit)
- TIMEOUT, 1000, cycles CHECK waits for valid_epass before forcing FAIL (>=2)
- TMR_W, 10, timer width; must satisfy 2**TMR_W >= TIMEOUT

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- sensor1  in  1  entry presence (synchronous level)
- sensor2  in  1  reader presence (synchronous level)
- sensor3  in  1  exit presence (synchronous level)
- valid_epass  in  2  10=pass, 01=fail, 00/11=pending
- enable  in  1  operator manual release, sampled only in HOLD
- init  out  1  high while both FSMs are idle and the queue is empty
- req_check  out  1  high while check FSM is in CHECK
- up  out  1  one-cycle open pulse
- down  out  1  one-cycle close pulse
- dis  out  1  level, high in HOLD (vehicle refused)
- barrier_open  out  1  level, high in OPEN
- occupancy  out  CNT_W  vehicles currently in lane
- timeout_err  out  1  one-cycle pulse when CHECK times out
- viol  out  1  one-cycle pulse on exit without an open barrier
- overflow  out  1  sticky; cleared only by reset

Behaviour:
- Reset (synchronous, highest priority):
  - All outputs 0 except init=1.
  - Queue empty; pend_cnt=0; timer=0; edge registers=0.
- Edge detect:
  - Each sensor is registered once.
  - s_rise = sensor & ~prev; s3_fall = ~sensor3 & prev3.
  - Events act in the cycle after the input edge; all outputs are registered.
- Occupancy:
  - +1 on s1_rise, -1 on s3_fall; unchanged if both occur in the same cycle.
  - Saturates at 0 and 2**CNT_W-1. An increment at max also sets overflow.
- Check FSM, states IDLE and CHECK:
  - IDLE: on s2_rise or pend_cnt>0, go to CHECK with timer=0. If the entry came from pend_cnt, decrement it.
  - CHECK, one action per cycle, in this priority:
    - valid_epass=10: push PASS, go to IDLE.
    - valid_epass=01: push FAIL, go to IDLE.
    - timer==TIMEOUT-1: push FAIL, pulse timeout_err, go to IDLE.
    - otherwise: timer+1.
  - s2_rise while in CHECK: pend_cnt+1, saturating at QDEPTH. Saturation sets overflow.
  - A pending vehicle re-enters CHECK at least one cycle after returning to IDLE.
- Verdict queue:
  - 1-bit-wide FIFO of QDEPTH entries; read/write pointers wrap modulo QDEPTH.
  - Push when full: verdict dropped, overflow=1.
  - Push and pop in the same cycle are both legal when not empty. On empty, the push completes and the pop is ignored.
- Barrier FSM, states CLOSED, OPEN, HOLD:
  - CLOSED:
    - Head=PASS: pulse up, go to OPEN.
    - Head=FAIL: go to HOLD.
  - HOLD: dis=1.
    - enable=1: pulse up, go to OPEN; the head is treated as paid.
  - OPEN, on s3_fall: pop the head.
    - If the new head is PASS: stay OPEN, no down pulse.
    - Otherwise (empty or FAIL): pulse down, go to CLOSED.
- Violations:
  - s3_fall while CLOSED or HOLD, or with the queue empty: pulse viol.
  - If the queue is not empty, pop the head. HOLD returns to CLOSED with dis dropping; no up or down pulse.
- up and down never assert in the same cycle.
- Reset mid-operation discards all queued verdicts and pending checks. A vehicle then inside the lane exits as a viol.

Test Plan:
- Single paid car: s1 rise, s2 rise, valid_epass=10 after 5 cycles, then s3 rise/fall.
  - Required: req_check high for 5 cycles; up pulse 1 cycle after the queue push.
  - barrier_open=1 until down 1 cycle after s3_fall; occupancy 0→1→0.
- Timeout: s2 rise, valid_epass held 00.
  - Required: timeout_err pulses at cycle TIMEOUT of CHECK, then dis=1.
  - enable=1 gives up pulse with dis=0; s3_fall gives down.
- Back-to-back PASS,PASS: two cars verified before the first exits.
  - Required: one up pulse; no down at the first s3_fall; down at the second s3_fall; occupancy peaks at 2.
- PASS then FAIL: the first s3_fall gives down, then dis=1 with the barrier closed.
  - s3_fall while in HOLD gives a viol pulse, dis=0, queue empty, and no up or down.
- Overflow (QDEPTH=4):
  - Six vehicles are verified PASS with no exit. Required: overflow=1 on the fifth push; pending saturation also sets it.
  - After reset: overflow=0, init=1, occupancy=0.
- Simultaneous events:
  - s1_rise with s3_fall: occupancy unchanged.
  - s2_rise during CHECK: pend_cnt=1 and a second CHECK follows; a fail verdict in it is queued as FAIL.

Source files
------------

// File: rtl/etc_lane_ctrl.sv
// Nonstop ETC lane controller: tracks vehicles between three sensors, queues one Epass
// verdict per vehicle and drives the barrier, holding refused vehicles for manual release.
module etc_lane_ctrl #(
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned TMR_W   = 10
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sensor1_i,
  input  logic             sensor2_i,
  input  logic             sensor3_i,
  input  logic [1:0]       valid_epass_i,
  input  logic             enable_i,
  output logic             init_o,
  output logic             req_check_o,
  output logic             up_o,
  output logic             down_o,
  output logic             dis_o,
  output logic             barrier_open_o,
  output logic [CNT_W-1:0] occupancy_o,
  output logic             timeout_err_o,
  output logic             viol_o,
  output logic             overflow_o
);

  localparam int unsigned PtrW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned QcntW = PtrW + 1;

  localparam logic [QcntW-1:0] QFull   = QcntW'(QDEPTH);
  localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OccMax  = '1;

  typedef enum logic {ChkIdle, ChkCheck} chk_state_e;
  typedef enum logic [1:0] {BarClosed, BarOpen, BarHold} bar_state_e;

  logic             s1_q, s2_q, s3_q;
  logic             s1_rise, s2_rise, s3_fall;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             occ_ovf;

  chk_state_e       chk_q, chk_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [QcntW-1:0] pend_q, pend_d;
  logic             pend_ovf;
  logic             push, push_val;
  logic             tout_q, tout_d;

  bar_state_e       bar_q, bar_d;
  logic             pop;
  logic             up_q, up_d, down_q, down_d, viol_q, viol_d;

  logic             mem_q [QDEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d, rd_nxt;
  logic [QcntW-1:0] qcnt_q, qcnt_d;
  logic             q_empty, q_full, push_ok, q_ovf;
  logic             head, nxt_head_vld, nxt_head;
  logic             ovf_q, ovf_d;

  assign s1_rise = sensor1_i & ~s1_q;
  assign s2_rise = sensor2_i & ~s2_q;
  assign s3_fall = ~sensor3_i & s3_q;

  always_comb begin
    occ_d   = occ_q;
    occ_ovf = 1'b0;
    if (s1_rise && !s3_fall) begin
      if (occ_q == OccMax) begin
        occ_ovf = 1'b1;
      end else begin
        occ_d = occ_q + CNT_W'(1);
      end
    end else if (s3_fall && !s1_rise && occ_q != '0) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_comb begin
    chk_d    = chk_q;
    tmr_d    = tmr_q;
    pend_d   = pend_q;
    pend_ovf = 1'b0;
    push     = 1'b0;
    push_val = 1'b0;
    tout_d   = 1'b0;
    unique case (chk_q)
      ChkIdle: begin
        // A fresh reader event takes precedence; a pending vehicle waits its turn.
        if (s2_rise) begin
          chk_d = ChkCheck;
          tmr_d = '0;
        end else if (pend_q != '0) begin
          chk_d  = ChkCheck;
          tmr_d  = '0;
          pend_d = pend_q - QcntW'(1);
        end
      end
      ChkCheck: begin
        if (valid_epass_i == 2'b10) begin
          push     = 1'b1;
          push_val = 1'b1;
          chk_d    = ChkIdle;
        end else if (valid_epass_i == 2'b01) begin
          push  = 1'b1;
          chk_d = ChkIdle;
        end else if (tmr_q == TmrLast) begin
          push   = 1'b1;
          tout_d = 1'b1;
          chk_d  = ChkIdle;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
        if (s2_rise) begin
          if (pend_q == QFull) begin
            pend_ovf = 1'b1;
          end else begin
            pend_d = pend_q + QcntW'(1);
          end
        end
      end
      default: chk_d = ChkIdle;
    endcase
  end

  assign q_empty = (qcnt_q == '0);
  assign q_full  = (qcnt_q == QFull);
  assign head    = mem_q[rd_q];
  assign rd_nxt  = rd_q + PtrW'(1);
  assign push_ok = push & ~q_full;
  assign q_ovf   = push & q_full;

  // Head after a pop: the second entry, or a verdict being pushed into a one-entry queue.
  assign nxt_head_vld = (qcnt_q > QcntW'(1)) || push;
  assign nxt_head     = (qcnt_q > QcntW'(1)) ? mem_q[rd_nxt] : push_val;

  always_comb begin
    bar_d  = bar_q;
    pop    = 1'b0;
    up_d   = 1'b0;
    down_d = 1'b0;
    viol_d = 1'b0;
    unique case (bar_q)
      BarClosed: begin
        if (s3_fall) begin
          viol_d = 1'b1;
          pop    = ~q_empty;
        end else if (!q_empty) begin
          if (head) begin
            up_d  = 1'b1;
            bar_d = BarOpen;
          end else begin
            bar_d = BarHold;
          end
        end
      end
      BarHold: begin
        if (s3_fall) begin
          viol_d = 1'b1;
          pop    = ~q_empty;
          bar_d  = BarClosed;
        end else if (enable_i) begin
          up_d  = 1'b1;
          bar_d = BarOpen;
        end
      end
      BarOpen: begin
        if (s3_fall) begin
          if (q_empty) begin
            viol_d = 1'b1;
            down_d = 1'b1;
            bar_d  = BarClosed;
          end else begin
            pop = 1'b1;
            if (!(nxt_head_vld && nxt_head)) begin
              down_d = 1'b1;
              bar_d  = BarClosed;
            end
          end
        end
      end
      default: bar_d = BarClosed;
    endcase
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    qcnt_d = qcnt_q;
    if (push_ok) begin
      wr_d = wr_q + PtrW'(1);
    end
    if (pop) begin
      rd_d = rd_nxt;
    end
    unique case ({push_ok, pop})
      2'b10:   qcnt_d = qcnt_q + QcntW'(1);
      2'b01:   qcnt_d = qcnt_q - QcntW'(1);
      default: qcnt_d = qcnt_q;
    endcase
    ovf_d = ovf_q | occ_ovf | pend_ovf | q_ovf;
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= push_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      occ_q  <= '0;
      chk_q  <= ChkIdle;
      tmr_q  <= '0;
      pend_q <= '0;
      tout_q <= 1'b0;
      bar_q  <= BarClosed;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      viol_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      qcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s1_q   <= sensor1_i;
      s2_q   <= sensor2_i;
      s3_q   <= sensor3_i;
      occ_q  <= occ_d;
      chk_q  <= chk_d;
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      tout_q <= tout_d;
      bar_q  <= bar_d;
      up_q   <= up_d;
      down_q <= down_d;
      viol_q <= viol_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      qcnt_q <= qcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign init_o         = (chk_q == ChkIdle) && (bar_q == BarClosed) && q_empty;
  assign req_check_o    = (chk_q == ChkCheck);
  assign dis_o          = (bar_q == BarHold);
  assign barrier_open_o = (bar_q == BarOpen);
  assign up_o           = up_q;
  assign down_o         = down_q;
  assign occupancy_o    = occ_q;
  assign timeout_err_o  = tout_q;
  assign viol_o         = viol_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_etc_lane_ctrl.sv
// Bench for etc_lane_ctrl: vector table, directed corner sequences and a randomized run,
// all checked against a queue-based lane model.
module tb_etc_lane_ctrl;

  localparam int QD = 4;
  localparam int CW = 4;
  localparam int TO = 20;
  localparam int TW = 5;
  localparam int OCC_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, s1, s2, s3, en;
  logic [1:0]    vp;
  logic          init, req, up, down, dis, bopen, tout, viol, ovf;
  logic [CW-1:0] occ;

  etc_lane_ctrl #(.QDEPTH(QD), .CNT_W(CW), .TIMEOUT(TO), .TMR_W(TW)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .sensor1_i      (s1),
    .sensor2_i      (s2),
    .sensor3_i      (s3),
    .valid_epass_i  (vp),
    .enable_i       (en),
    .init_o         (init),
    .req_check_o    (req),
    .up_o           (up),
    .down_o         (down),
    .dis_o          (dis),
    .barrier_open_o (bopen),
    .occupancy_o    (occ),
    .timeout_err_o  (tout),
    .viol_o         (viol),
    .overflow_o     (ovf)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_up = 0;
  logic c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;

  // Lane model: verdicts live in a plain queue, the rest are counters and flags.
  bit m_p1, m_p2, m_p3, m_checking, m_ovf;
  bit m_up, m_down, m_tout, m_viol;
  int m_occ, m_pend, m_wait, m_bar;  // m_bar: 0 closed, 1 open, 2 hold
  bit m_q[$];

  function automatic logic [13:0] mk(bit i, bit q, bit u, bit d, bit ds, bit o, int oc,
                                     bit to, bit vi, bit ov);
    return {i, q, u, d, ds, o, 4'(oc), to, vi, ov};
  endfunction

  function automatic logic [13:0] model_out();
    return mk(!m_checking && m_bar == 0 && m_q.size() == 0, m_checking, m_up, m_down,
              m_bar == 2, m_bar == 1, m_occ, m_tout, m_viol, m_ovf);
  endfunction

  function automatic logic [13:0] dut_out();
    return {init, req, up, down, dis, bopen, occ, tout, viol, ovf};
  endfunction

  function automatic void model_clock(bit r, bit a1, bit a2, bit a3, bit [1:0] v, bit e);
    bit r1, r2, f3, pop, nh_pass;
    int verdict, old_size;
    m_up = 0; m_down = 0; m_tout = 0; m_viol = 0;
    if (r) begin
      m_p1 = 0; m_p2 = 0; m_p3 = 0; m_checking = 0; m_ovf = 0;
      m_occ = 0; m_pend = 0; m_wait = 0; m_bar = 0;
      m_q.delete();
      return;
    end
    r1 = a1 && !m_p1;
    r2 = a2 && !m_p2;
    f3 = !a3 && m_p3;
    if (r1 && !f3) begin
      if (m_occ == OCC_MAX) m_ovf = 1; else m_occ++;
    end else if (f3 && !r1 && m_occ > 0) begin
      m_occ--;
    end
    verdict = -1;
    if (!m_checking) begin
      if (r2) begin
        m_checking = 1; m_wait = 0;
      end else if (m_pend > 0) begin
        m_checking = 1; m_wait = 0; m_pend--;
      end
    end else begin
      if (v == 2'b10) begin
        verdict = 1; m_checking = 0;
      end else if (v == 2'b01) begin
        verdict = 0; m_checking = 0;
      end else if (m_wait == TO - 1) begin
        verdict = 0; m_tout = 1; m_checking = 0;
      end else begin
        m_wait++;
      end
      if (r2) begin
        if (m_pend == QD) m_ovf = 1; else m_pend++;
      end
    end
    pop = 0;
    if (m_bar == 0) begin
      if (f3) begin
        m_viol = 1; pop = (m_q.size() > 0);
      end else if (m_q.size() > 0) begin
        if (m_q[0]) begin m_up = 1; m_bar = 1; end
        else m_bar = 2;
      end
    end else if (m_bar == 2) begin
      if (f3) begin
        m_viol = 1; pop = (m_q.size() > 0); m_bar = 0;
      end else if (e) begin
        m_up = 1; m_bar = 1;
      end
    end else if (f3) begin
      if (m_q.size() == 0) begin
        m_viol = 1; m_down = 1; m_bar = 0;
      end else begin
        pop = 1;
        nh_pass = (m_q.size() > 1) ? m_q[1] : (verdict == 1);
        if (!nh_pass) begin m_down = 1; m_bar = 0; end
      end
    end
    old_size = m_q.size();
    if (pop) void'(m_q.pop_front());
    if (verdict >= 0) begin
      if (old_size == QD) m_ovf = 1; else m_q.push_back(verdict == 1);
    end
    m_p1 = a1; m_p2 = a2; m_p3 = a3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
  endtask

  task automatic step(input logic r, input logic a1, input logic a2, input logic a3,
                      input logic [1:0] v, input logic e);
    rst = r; s1 = a1; s2 = a2; s3 = a3; vp = v; en = e;
    model_clock(r, a1, a2, a3, v, e);
    @(posedge clk);
    #1;
    if (up) n_up++;
    chk("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic t(input logic [1:0] v = 2'b00, input logic e = 1'b0);
    step(1'b0, c1, c2, c3, v, e);
  endtask

  task automatic do_reset();
    c1 = 0; c2 = 0; c3 = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic car(input logic [1:0] verdict);
    c1 = 1; t();
    c2 = 1; t();
    t(verdict);
    c1 = 0; c2 = 0; t();
  endtask

  typedef struct {
    logic r, a1, a2, a3;
    logic [1:0] v;
    logic e;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    rst = 1; s1 = 0; s2 = 0; s3 = 0; vp = 0; en = 0;
    // Single paid car, one row per clock.
    tbl[0]  = '{1, 0, 0, 0, 2'b00, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{0, 1, 0, 0, 2'b00, 0, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[2]  = '{0, 1, 1, 0, 2'b00, 0, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[3]  = '{0, 1, 1, 0, 2'b00, 0, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[4]  = '{0, 0, 1, 0, 2'b00, 0, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[5]  = '{0, 0, 0, 0, 2'b00, 0, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[6]  = '{0, 0, 0, 0, 2'b00, 0, mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[7]  = '{0, 0, 0, 0, 2'b10, 0, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
    tbl[8]  = '{0, 0, 0, 0, 2'b00, 0, mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 0)};
    tbl[9]  = '{0, 0, 0, 0, 2'b00, 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0)};
    tbl[10] = '{0, 0, 0, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0)};
    tbl[11] = '{0, 0, 0, 0, 2'b00, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0)};
    tbl[12] = '{0, 0, 0, 0, 2'b00, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].v, tbl[i].e);
      chk($sformatf("tbl[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Verification timeout, then manual release.
    do_reset();
    c1 = 1; t();
    c2 = 1; t();
    chk("to_req", 32'(req), 1);
    for (int i = 1; i <= TO; i++) begin
      t();
      if (i == TO - 1) chk("to_early", 32'({tout, req}), 32'b01);
      if (i == TO) chk("to_pulse", 32'({tout, req}), 32'b10);
    end
    t();
    chk("to_hold", 32'({dis, bopen}), 32'b10);
    t(2'b00, 1'b1);
    chk("to_release", 32'({up, dis, bopen}), 32'b101);
    c3 = 1; t();
    c3 = 0; t();
    chk("to_exit", 32'({down, bopen, viol}), 32'b100);

    // Back-to-back paid vehicles.
    do_reset();
    n_up = 0;
    car(2'b10);
    car(2'b10);
    chk("b2b_peak", 32'(occ), 2);
    c3 = 1; t();
    c3 = 0; t();
    chk("b2b_first", 32'({down, bopen}), 32'b01);
    c3 = 1; t();
    c3 = 0; t();
    chk("b2b_second", 32'({down, bopen}), 32'b10);
    chk("b2b_ups", 32'(n_up), 1);
    chk("b2b_occ", 32'(occ), 0);

    // Paid then refused vehicle; the refused one exits through HOLD.
    do_reset();
    car(2'b10);
    car(2'b01);
    c3 = 1; t();
    c3 = 0; t();
    chk("pf_first", 32'({down, bopen, dis}), 32'b100);
    t();
    chk("pf_hold", 32'({dis, bopen}), 32'b10);
    c3 = 1; t();
    c3 = 0; t();
    chk("pf_viol", 32'({viol, dis, up, down}), 32'b1000);
    chk("pf_empty", 32'(init), 1);

    // Verdict queue overflow, then reset clears it.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      c2 = 1; t();
      t(2'b10);
      c2 = 0; t();
      if (k == 3) chk("ovf_4", 32'(ovf), 0);
      if (k == 4) chk("ovf_5", 32'(ovf), 1);
    end
    do_reset();
    chk("rst_clear", 32'({ovf, init, occ}), 32'({1'b0, 1'b1, 4'b0000}));

    // Pending-count saturation.
    c2 = 1; t();
    for (int k = 1; k <= 5; k++) begin
      c2 = 0; t();
      c2 = 1; t();
      if (k == 4) chk("pend_4", 32'(ovf), 0);
      if (k == 5) chk("pend_5", 32'(ovf), 1);
    end

    // Simultaneous entry/exit, and a pending check that fails.
    do_reset();
    c1 = 1; t();
    c1 = 0; c3 = 1; t();
    c1 = 1; c3 = 0; t();
    chk("sim_occ", 32'({occ, viol}), 32'({4'd1, 1'b1}));
    c1 = 0; c2 = 1; t();
    chk("sim_req", 32'(req), 1);
    c2 = 0; t();
    c2 = 1; t();
    t(2'b10);
    chk("sim_idle", 32'(req), 0);
    c2 = 0; t();
    chk("sim_recheck", 32'(req), 1);
    t(2'b01);
    chk("sim_done", 32'(req), 0);
    c3 = 1; t();
    c3 = 0; t();
    chk("sim_fail_down", 32'(down), 1);
    t();
    chk("sim_fail_hold", 32'(dis), 1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int rv;
      logic [1:0] v;
      if ($urandom_range(5) == 0) c1 = ~c1;
      if ($urandom_range(5) == 0) c2 = ~c2;
      if ($urandom_range(5) == 0) c3 = ~c3;
      rv = int'($urandom_range(31));
      v = (rv < 4) ? 2'b10 : (rv < 6) ? 2'b01 : (rv == 6) ? 2'b11 : 2'b00;
      step(($urandom_range(299) == 0), c1, c2, c3, v, ($urandom_range(9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
